// File: rtl/uart_cadru_timp.sv
// uart_cadru_timp -- ASCII time-set frame parser.
//
// Turns frames of the form  'T' H1 H0 ':' M1 M0 TERM  (TERM = CR or LF),
// delivered one byte per rx_valid strobe by the UART receiver, into binary
// hours/minutes for the time counter's load path.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   rx_data   in   [7:0] received byte, qualified by rx_valid
//   rx_valid  in   one-cycle strobe per received byte
//   ore       out  [4:0] last accepted hours (0..23), registered
//   minute    out  [5:0] last accepted minutes (0..59), registered
//   load      out  one-cycle pulse when ore/minute take a new value
//   err       out  one-cycle pulse on a rejected frame or inter-byte timeout
module uart_cadru_timp #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TMR_W          = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [4:0] ore,
    output logic [5:0] minute,
    output logic       load,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_H1,
        S_H0,
        S_COL,
        S_M1,
        S_M0,
        S_END
    } state_t;

    localparam logic [7:0] CH_T   = 8'h54;
    localparam logic [7:0] CH_COL = 8'h3A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic [4:0]       ore_d;
    logic [5:0]       minute_d;
    logic             load_d, err_d;

    logic [3:0] digit;
    logic       is_digit;
    logic       is_t;
    logic       timeout;
    logic       bad;
    logic [5:0] hours_try;

    // x10 as shift-and-add; widest operand here is 5*10+9 = 59, fits 6 bits.
    function automatic logic [5:0] x10(input logic [3:0] d);
        x10 = ({2'b00, d} << 3) + ({2'b00, d} << 1);
    endfunction

    assign digit     = 4'(rx_data - 8'h30);
    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_t      = (rx_data == CH_T);
    // Candidate hour value while sitting in S_H0; h1 <= 2 so 29 max, no overflow.
    assign hours_try = x10(h1_q) + {2'b00, digit};
    // A byte arriving in the terminal timer cycle wins over the timeout.
    assign timeout   = (state_q != S_IDLE) && !rx_valid &&
                       (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        h1_d     = h1_q;
        h0_d     = h0_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        ore_d    = ore;
        minute_d = minute;
        load_d   = 1'b0;
        err_d    = 1'b0;
        bad      = 1'b0;

        if (rx_valid) begin
            case (state_q)
                S_IDLE: if (is_t) state_d = S_H1;
                S_H1: begin
                    if (rx_data inside {[8'h30:8'h32]}) begin
                        h1_d    = digit;
                        state_d = S_H0;
                    end else bad = 1'b1;
                end
                S_H0: begin
                    if (is_digit && hours_try <= 6'd23) begin
                        h0_d    = digit;
                        state_d = S_COL;
                    end else bad = 1'b1;
                end
                S_COL: begin
                    if (rx_data == CH_COL) state_d = S_M1;
                    else bad = 1'b1;
                end
                S_M1: begin
                    if (rx_data inside {[8'h30:8'h35]}) begin
                        m1_d    = digit;
                        state_d = S_M0;
                    end else bad = 1'b1;
                end
                S_M0: begin
                    if (is_digit) begin
                        m0_d    = digit;
                        state_d = S_END;
                    end else bad = 1'b1;
                end
                S_END: begin
                    if (rx_data == CH_CR || rx_data == CH_LF) begin
                        state_d  = S_IDLE;
                        load_d   = 1'b1;
                        ore_d    = 5'(x10(h1_q) + {2'b00, h0_q});
                        minute_d = x10(m1_q) + {2'b00, m0_q};
                    end else bad = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase

            // A stray 'T' is most likely the start of a fresh frame: resync on it.
            if (bad) begin
                err_d   = 1'b1;
                state_d = is_t ? S_H1 : S_IDLE;
            end
        end else if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end

        if (rx_valid || state_q == S_IDLE || timeout) timer_d = '0;
        else                                          timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            h1_q    <= '0;
            h0_q    <= '0;
            m1_q    <= '0;
            m0_q    <= '0;
            ore     <= '0;
            minute  <= '0;
            load    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            h1_q    <= h1_d;
            h0_q    <= h0_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            ore     <= ore_d;
            minute  <= minute_d;
            load    <= load_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_cadru_timp.sv
// tb_uart_cadru_timp -- self-checking bench for uart_cadru_timp.
// A byte-queue frame model predicts load/err/ore/minute every cycle; a vector
// table adds per-frame pulse counts and final values; hand sequences cover
// timeout, mid-frame reset and reset state.
module tb_uart_cadru_timp;

    localparam int TO = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [4:0] ore;
    logic [5:0] minute;
    logic       load;
    logic       err;

    uart_cadru_timp #(.TIMEOUT_CYCLES(TO), .TMR_W(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .ore     (ore),
        .minute  (minute),
        .load    (load),
        .err     (err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int nload = 0;
    int nerr  = 0;

    // ---------------- reference model ----------------
    logic [7:0] pend[$];
    int         gap_cnt = 0;
    int         m_ore = 0, m_min = 0;
    bit         m_load = 0, m_err = 0;

    function automatic int dv(input logic [7:0] c);
        return int'(c) - 48;
    endfunction

    function automatic bit byte_ok(input int pos, input logic [7:0] d);
        bit dig;
        dig = (d >= "0") && (d <= "9");
        case (pos)
            1: return (d >= "0") && (d <= "2");
            2: return dig && (dv(pend[1]) * 10 + dv(d) <= 23);
            3: return d == ":";
            4: return (d >= "0") && (d <= "5");
            5: return dig;
            6: return (d == 8'h0D) || (d == 8'h0A);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input bit v, input logic [7:0] d);
        int pos;
        m_load = 0;
        m_err  = 0;
        if (v) begin
            gap_cnt = 0;
            if (pend.size() == 0) begin
                if (d == "T") pend.push_back(d);
            end else begin
                pos = pend.size();
                if (!byte_ok(pos, d)) begin
                    m_err = 1;
                    pend.delete();
                    if (d == "T") pend.push_back(d);
                end else if (pos == 6) begin
                    m_load = 1;
                    m_ore  = dv(pend[1]) * 10 + dv(pend[2]);
                    m_min  = dv(pend[4]) * 10 + dv(pend[5]);
                    pend.delete();
                end else begin
                    pend.push_back(d);
                end
            end
        end else if (pend.size() != 0) begin
            gap_cnt++;
            if (gap_cnt == TO) begin
                m_err = 1;
                pend.delete();
                gap_cnt = 0;
            end
        end
    endtask

    task automatic model_reset();
        pend.delete();
        gap_cnt = 0;
        m_ore = 0;
        m_min = 0;
        m_load = 0;
        m_err = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic step(input bit v, input logic [7:0] d);
        @(negedge clock);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        @(posedge clock);
        model_step(v, d);
        #1;
        tests++;
        if (load !== m_load || err !== m_err || int'(ore) != m_ore || int'(minute) != m_min) begin
            fails++;
            $display("FAIL cycle t=%0t: got load=%0b err=%0b ore=%0d min=%0d, want load=%0b err=%0b ore=%0d min=%0d",
                     $time, load, err, ore, minute, m_load, m_err, m_ore, m_min);
        end
        if (load === 1'b1) nload++;
        if (err === 1'b1) nerr++;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            if (i != 0) for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
            step(1'b1, s.getc(i));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string frame;
        int    gap;
        int    loads;
        int    errs;
        int    e_ore;
        int    e_min;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int l0, e0, got, k;
        logic [7:0] fb[7];
        logic [7:0] d;

        vecs[0]  = '{"T12:34\r",         10, 1, 0, 12, 34};
        vecs[1]  = '{"T23:59\nT00:00\r",  0, 2, 0,  0,  0};
        vecs[2]  = '{"T24:00\r",          3, 0, 1,  0,  0};
        vecs[3]  = '{"T1T09:05\r",        1, 1, 1,  9,  5};
        vecs[4]  = '{"T19:60\r",          2, 0, 1,  9,  5};
        vecs[5]  = '{"AT05:07\n",         1, 1, 0,  5,  7};
        vecs[6]  = '{"T2:",               1, 0, 1,  5,  7};
        vecs[7]  = '{"T05:07T10:00\r",    0, 1, 1, 10,  0};
        vecs[8]  = '{"T00:00\r\r",        2, 1, 0,  0,  0};
        vecs[9]  = '{"T13:45\r",         99, 1, 0, 13, 45};
        vecs[10] = '{"T12x4",             1, 0, 1, 13, 45};
        vecs[11] = '{"T21:43\r",          0, 1, 0, 21, 43};

        // Reset state.
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_ore", int'(ore), 0);
        check("reset_minute", int'(minute), 0);
        check("reset_pulses", int'({load, err}), 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Table-driven frames.
        for (int v = 0; v < 12; v++) begin
            l0 = nload;
            e0 = nerr;
            send_str(vecs[v].frame, vecs[v].gap);
            idle(4);
            check({"loads_", vecs[v].frame}, nload - l0, vecs[v].loads);
            check({"errs_", vecs[v].frame}, nerr - e0, vecs[v].errs);
            check({"ore_", vecs[v].frame}, int'(ore), vecs[v].e_ore);
            check({"minute_", vecs[v].frame}, int'(minute), vecs[v].e_min);
        end

        // Inter-byte timeout: err exactly TO cycles after the ':' strobe.
        send_str("T08:", 2);
        got = -1;
        k = 0;
        while (k < TO + 50 && got < 0) begin
            k++;
            step(1'b0, 8'h00);
            if (err === 1'b1) got = k;
        end
        check("timeout_cycles", got, TO);
        l0 = nload;
        e0 = nerr;
        send_str("30\r", 1);
        idle(3);
        check("after_timeout_loads", nload - l0, 0);
        check("after_timeout_errs", nerr - e0, 0);

        // Mid-frame asynchronous reset (outputs currently 21/43).
        send_str("T11:2", 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_reset_ore", int'(ore), 0);
        check("async_reset_minute", int'(minute), 0);
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        l0 = nload;
        send_str("T07:45\r", 1);
        idle(2);
        check("post_reset_loads", nload - l0, 1);
        check("post_reset_ore", int'(ore), 7);
        check("post_reset_minute", int'(minute), 45);

        // Randomized frames with occasional corruption and junk.
        for (int f = 0; f < 60; f++) begin
            fb[0] = "T";
            fb[1] = 8'(48 + $urandom_range(0, 2));
            fb[2] = 8'(48 + ((fb[1] == "2") ? $urandom_range(0, 3) : $urandom_range(0, 9)));
            fb[3] = ":";
            fb[4] = 8'(48 + $urandom_range(0, 5));
            fb[5] = 8'(48 + $urandom_range(0, 9));
            fb[6] = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            if ($urandom_range(0, 3) == 0) fb[$urandom_range(1, 6)] = 8'($urandom_range(32, 126));
            if ($urandom_range(0, 7) == 0) step(1'b1, 8'($urandom_range(32, 126)));
            for (int i = 0; i < 7; i++) begin
                step(1'b1, fb[i]);
                idle($urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0) begin
                d = 8'($urandom);
                step(1'b1, d);
            end
        end
        idle(TO + 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cadru_timp.md
Name: uart_cadru_timp

Overview:
- Parses ASCII time-set frames from the UART byte receiver into binary hours/minutes plus a one-cycle load strobe.
- Sits directly downstream of the UART byte receiver and upstream of the time counter's UART load path (ore / minute / load).
- Rejects malformed, out-of-range or stalled frames without disturbing the last valid time.

Parameters:
- TIMEOUT_CYCLES, default 50_000_000: maximum clock cycles allowed between consecutive bytes of one frame (1 s at 50 MHz).
- TMR_W, default 26: width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- ore  output  5  last accepted hours, 0..23, registered.
- minute  output  6  last accepted minutes, 0..59, registered.
- load  output  1  one-cycle pulse when ore/minute take a new value.
- err  output  1  one-cycle pulse on a rejected frame or a timeout.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ore=0, minute=0, load=0, err=0, timer=0, digit registers=0.
- Frame format: 'T'(0x54) H1 H0 ':'(0x3A) M1 M0 TERM, where TERM is CR(0x0D) or LF(0x0A).
- Only cycles with rx_valid=1 advance the FSM. rx_data is ignored otherwise.
- IDLE: 'T' goes to S_H1. Any other byte is silently ignored, with no err.
- S_H1: '0'..'2' stores h1 and goes to S_H0.
- S_H0: '0'..'9' stores h0 and goes to S_COL, provided h1*10+h0 <= 23. So '2' followed by '4'..'9' is invalid.
- S_COL: ':' goes to S_M1.
- S_M1: '0'..'5' stores m1 and goes to S_M0.
- S_M0: '0'..'9' stores m0 and goes to S_END.
- S_END: CR or LF completes the frame and the FSM returns to IDLE.
- On completion, on the next rising edge: ore = h1*10+h0 (5 bits), minute = m1*10+m0 (6 bits), load=1 for exactly one cycle. Latency is one cycle from the TERM strobe to load.
- Arithmetic: digit = rx_data - 0x30, 4 bits. The x10 multiply is done as (d<<3)+(d<<1) at the output width. No truncation is possible within the validated ranges.
- Invalid byte in any non-IDLE state:
  - err=1 for one cycle, on the next edge.
  - If the invalid byte is 'T', the FSM resynchronises to S_H1; otherwise it returns to IDLE.
  - ore/minute are unchanged and load=0.
- 'T' is invalid in every non-IDLE state. It always pulses err and restarts the frame.
- Timeout:
  - The timer clears on every rx_valid and counts while state != IDLE.
  - When the timer reaches TIMEOUT_CYCLES-1 with no rx_valid: FSM goes to IDLE, err pulses once, timer clears.
  - If rx_valid arrives in that same cycle, the byte wins and no timeout occurs.
  - The timer is held at 0 while in IDLE.
- load and err are never asserted together.
- Back-to-back frames:
  - A 'T' in IDLE on the cycle right after TERM is accepted normally.
  - A load pulse from the previous frame does not block the new frame.
- Reset mid-frame: discards the partial frame and forces ore=0, minute=0 immediately, without waiting for a clock edge.
- Outputs are pure registers with no combinational path from rx_data.

Test Plan:
- Send "T12:34\r", one byte every 10 cycles -> one cycle after the CR strobe, load=1 for 1 cycle, ore=12, minute=34, err=0 throughout.
- Send "T23:59\n", then "T00:00\r" back-to-back -> two load pulses; the outputs read 23/59, then 0/0.
- Send "T24:00\r" -> err pulses once, on the edge after the '4' strobe. No load, outputs keep their previous value, and the trailing bytes are ignored in IDLE with no further err.
- Send "T1" then "T09:05\r" -> err pulses on the second 'T', then load with ore=9, minute=5.
- Send "T08:", then idle for TIMEOUT_CYCLES with the parameter overridden to 100 -> err pulse exactly 100 cycles after the ':' strobe, state returns to IDLE. A following "30\r" causes no load.
- Send "T11:2", then assert reset low for 3 cycles, release, and send "T07:45\r" -> ore/minute read 0 during reset, then load with ore=7, minute=45.
